spi_slave_core: RTL and testbench

Parametrised SPI slave shifter for the actuator controller's user-project SPI port (sclk/mosi/ss_n in, miso out). It oversamples the SPI pins in the `clock` domain and supports configurable word width, all four CPOL/CPHA modes, multi-word bursts under one `ss_n` assertion and a loopback (echo) mode. Received words go to the register bank; transmit words come from a one-deep holding buffer. It generalises the fixed 32-bit, mode-0 passthrough shifter.

---
 rtl/spi_slave_core.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_core.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI slave shifter oversampled in the system clock domain: configurable width and CPOL/CPHA,
// multi-word bursts, one-deep transmit holding buffer and optional receive-to-transmit echo.
module spi_slave_core #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic             loopback,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_overrun,
  input  logic             rx_ack,
  output logic             frame_error
);

  localparam int unsigned     CntW       = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit    = CntW'(WIDTH - 1);
  localparam logic            IdleClk    = (CPOL != 0);
  localparam bit              SampleRise = (CPOL == CPHA);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-2:0] rx_shift_q;
  logic [WIDTH-1:0] tx_shift_q, tx_buf_q, rx_data_q;
  logic             tx_ready_q, rx_valid_q, rx_pend_q, rx_overrun_q, frame_error_q, miso_oe_q;

  logic             sclk_s, ss_s, mosi_s;
  logic             sample_edge, shift_edge, ss_fall, ss_rise;
  logic             active, complete, abort, idle_move, reload;
  logic [WIDTH-1:0] rx_word, reload_word;

  // ss_n resets as "selected" so a frame already running at reset release is ignored until
  // ss_n has been seen high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{IdleClk}};
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= IdleClk;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sample_edge = SampleRise ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);
    shift_edge  = SampleRise ? (~sclk_s & sclk_prev_q) : (sclk_s & ~sclk_prev_q);
    ss_fall     = ss_prev_q & ~ss_s;
    ss_rise     = ~ss_prev_q & ss_s;
    active      = (state_q == StActive);
    complete    = active & ~ss_rise & sample_edge & (cnt_q == LastBit);
    abort       = active & ss_rise & (cnt_q != '0);
    idle_move   = ~active & ~tx_ready_q;
    reload      = complete | abort | idle_move;
    rx_word     = {rx_shift_q, mosi_s};
    reload_word = '0;
    if (!tx_ready_q) begin
      reload_word = tx_buf_q;
    end else if (loopback) begin
      reload_word = complete ? rx_word : rx_data_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_pend_q     <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_error_q <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      rx_valid_q    <= complete;
      frame_error_q <= abort;

      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q   <= StActive;
            cnt_q     <= '0;
            miso_oe_q <= 1'b1;
          end
        end
        StActive: begin
          if (ss_rise) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            miso_oe_q <= 1'b0;
          end else if (sample_edge) begin
            rx_shift_q <= rx_word[WIDTH-2:0];
            cnt_q      <= complete ? '0 : cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      // A zero count means the MSB of a fresh word is already on miso, so that shift edge is
      // skipped; this covers both the CPHA=1 leading edge and the CPHA=0 post-word trailing edge.
      if (reload) begin
        tx_shift_q <= reload_word;
      end else if (active && !ss_rise && shift_edge && cnt_q != '0) begin
        tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
      end

      if (tx_load && tx_ready_q) begin
        tx_buf_q   <= tx_data;
        tx_ready_q <= 1'b0;
      end else if (reload && !tx_ready_q) begin
        tx_ready_q <= 1'b1;
      end

      if (complete) begin
        rx_data_q    <= rx_word;
        rx_pend_q    <= 1'b1;
        rx_overrun_q <= ~rx_ack & (rx_overrun_q | rx_pend_q);
      end else if (rx_ack) begin
        rx_pend_q    <= 1'b0;
        rx_overrun_q <= 1'b0;
      end
    end
  end

  assign miso        = tx_shift_q[WIDTH-1];
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: lane 0 is a 32-bit mode-0 slave, lanes 1..3 are 8-bit slaves in modes 1..3.
// Time unit is arbitrary: clock period 250, SPI half period 1000 (4 clocks).
module tb_spi_slave_core;

  logic        clock;
  logic        reset_n;
  logic        sclk_a [4];
  logic        ss_a [4];
  logic        tx_load_a [4];
  logic        mosi, loopback, rx_ack;
  logic [31:0] tx_data0;
  logic [7:0]  tx_data8;
  logic        miso_a [4];
  logic        miso_oe_a [4];
  logic        tx_ready_a [4];
  logic        rx_valid_a [4];
  logic        rx_overrun_a [4];
  logic        frame_error_a [4];
  logic [31:0] rx_data0;
  logic [7:0]  rx_data8 [1:3];

  int          n_tests = 0;
  int          n_fail = 0;
  int          rxv_cnt [4] = '{0, 0, 0, 0};
  int          fe_cnt [4] = '{0, 0, 0, 0};
  logic [63:0] last_rx [4] = '{64'd0, 64'd0, 64'd0, 64'd0};

  spi_slave_core #(.WIDTH(32), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk_a[0]), .ss_n(ss_a[0]), .mosi(mosi),
    .miso(miso_a[0]), .miso_oe(miso_oe_a[0]), .loopback(loopback), .tx_data(tx_data0),
    .tx_load(tx_load_a[0]), .tx_ready(tx_ready_a[0]), .rx_data(rx_data0),
    .rx_valid(rx_valid_a[0]), .rx_overrun(rx_overrun_a[0]), .rx_ack(rx_ack),
    .frame_error(frame_error_a[0])
  );

  for (genvar m = 1; m < 4; m++) begin : g_mode
    spi_slave_core #(.WIDTH(8), .CPOL(m / 2), .CPHA(m % 2), .SYNC_STAGES(2)) u_dut (
      .clock(clock), .reset_n(reset_n), .sclk(sclk_a[m]), .ss_n(ss_a[m]), .mosi(mosi),
      .miso(miso_a[m]), .miso_oe(miso_oe_a[m]), .loopback(loopback), .tx_data(tx_data8),
      .tx_load(tx_load_a[m]), .tx_ready(tx_ready_a[m]), .rx_data(rx_data8[m]),
      .rx_valid(rx_valid_a[m]), .rx_overrun(rx_overrun_a[m]), .rx_ack(rx_ack),
      .frame_error(frame_error_a[m])
    );
  end

  initial clock = 1'b0;
  always #125 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid_a[0]) begin
      rxv_cnt[0] = rxv_cnt[0] + 1;
      last_rx[0] = {32'd0, rx_data0};
    end
    if (frame_error_a[0]) fe_cnt[0] = fe_cnt[0] + 1;
    for (int k = 1; k < 4; k++) begin
      if (rx_valid_a[k]) begin
        rxv_cnt[k] = rxv_cnt[k] + 1;
        last_rx[k] = {56'd0, rx_data8[k]};
      end
      if (frame_error_a[k]) fe_cnt[k] = fe_cnt[k] + 1;
    end
  end

  initial begin
    #30000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic ss_low(input int lane);
    ss_a[lane] = 1'b0;
    #1500;
  endtask

  task automatic ss_high(input int lane);
    #1000;
    ss_a[lane] = 1'b1;
    #2000;
  endtask

  task automatic do_load(input int lane, input logic [31:0] d);
    @(posedge clock);
    #50;
    tx_data0        = d;
    tx_data8        = d[7:0];
    tx_load_a[lane] = 1'b1;
    @(posedge clock);
    #50;
    tx_load_a[lane] = 1'b0;
  endtask

  task automatic ack_pulse();
    @(posedge clock);
    #50 rx_ack = 1'b1;
    @(posedge clock);
    #50 rx_ack = 1'b0;
  endtask

  // Master side of one word: drives mosi MSB first, returns the bits seen on miso.
  task automatic xfer_word(input int lane, input int cpol, input int cpha, input int nbits,
                           input logic [63:0] data, output logic [63:0] got);
    logic idle;
    idle = (cpol != 0);
    got  = '0;
    for (int i = 0; i < nbits; i++) begin
      if (cpha == 0) begin
        mosi = data[nbits-1-i];
        #1000;
        got = {got[62:0], miso_a[lane]};
        sclk_a[lane] = ~idle;
        #1000;
        sclk_a[lane] = idle;
      end else begin
        sclk_a[lane] = ~idle;
        mosi = data[nbits-1-i];
        #1000;
        got = {got[62:0], miso_a[lane]};
        sclk_a[lane] = idle;
        #1000;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #600;
    n_tests++; if (miso_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL rst_miso got=%b exp=0", miso_a[0]); end
    @(posedge clock);
    #50 reset_n = 1'b1;
    #500;
    n_tests++; if (miso_oe_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL rst_miso_oe got=%b exp=0", miso_oe_a[0]); end
    n_tests++; if (tx_ready_a[0] !== 1'b1) begin n_fail++;
      $display("FAIL rst_tx_ready got=%b exp=1", tx_ready_a[0]); end
    n_tests++; if (rx_data0 !== 32'h0) begin n_fail++;
      $display("FAIL rst_rx_data got=%h exp=0", rx_data0); end
    n_tests++; if (rx_valid_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL rst_rx_valid got=%b exp=0", rx_valid_a[0]); end
    n_tests++; if (rx_overrun_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL rst_rx_overrun got=%b exp=0", rx_overrun_a[0]); end
    n_tests++; if (frame_error_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL rst_frame_error got=%b exp=0", frame_error_a[0]); end
  endtask

  task automatic test_loopback();
    logic [63:0] got;
    int c;
    loopback = 1'b1;
    c = rxv_cnt[0];
    ss_low(0);
    xfer_word(0, 0, 0, 32, 64'hBEEFFACE, got);
    ss_high(0);
    n_tests++; if (got[31:0] !== 32'h0) begin n_fail++;
      $display("FAIL lb_miso1 got=%h exp=00000000", got[31:0]); end
    n_tests++; if (rx_data0 !== 32'hBEEFFACE) begin n_fail++;
      $display("FAIL lb_rx1 got=%h exp=beefface", rx_data0); end
    ack_pulse();
    ss_low(0);
    xfer_word(0, 0, 0, 32, 64'h0, got);
    ss_high(0);
    n_tests++; if (got[31:0] !== 32'hBEEFFACE) begin n_fail++;
      $display("FAIL lb_miso2 got=%h exp=beefface", got[31:0]); end
    n_tests++; if (rx_data0 !== 32'h0) begin n_fail++;
      $display("FAIL lb_rx2 got=%h exp=00000000", rx_data0); end
    n_tests++; if (rxv_cnt[0] - c !== 2) begin n_fail++;
      $display("FAIL lb_valid_count got=%0d exp=2", rxv_cnt[0] - c); end
  endtask

  task automatic test_burst();
    logic [31:0] words [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    logic [31:0] exp_miso [3] = '{32'hA5A5A5A5, 32'h0, 32'h0};
    logic [63:0] got;
    int c;
    loopback = 1'b0;
    ack_pulse();
    do_load(0, 32'hA5A5A5A5);
    #500;
    n_tests++; if (tx_ready_a[0] !== 1'b1) begin n_fail++;
      $display("FAIL burst_tx_ready_idle got=%b exp=1", tx_ready_a[0]); end
    c = rxv_cnt[0];
    ss_low(0);
    n_tests++; if (miso_oe_a[0] !== 1'b1) begin n_fail++;
      $display("FAIL burst_miso_oe_on got=%b exp=1", miso_oe_a[0]); end
    for (int w = 0; w < 3; w++) begin
      xfer_word(0, 0, 0, 32, {32'd0, words[w]}, got);
      n_tests++; if (got[31:0] !== exp_miso[w]) begin n_fail++;
        $display("FAIL burst_miso[%0d] got=%h exp=%h", w, got[31:0], exp_miso[w]); end
      n_tests++; if (last_rx[0][31:0] !== words[w]) begin n_fail++;
        $display("FAIL burst_rx[%0d] got=%h exp=%h", w, last_rx[0][31:0], words[w]); end
    end
    ss_high(0);
    n_tests++; if (miso_oe_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL burst_miso_oe_off got=%b exp=0", miso_oe_a[0]); end
    n_tests++; if (rxv_cnt[0] - c !== 3) begin n_fail++;
      $display("FAIL burst_valid_count got=%0d exp=3", rxv_cnt[0] - c); end
  endtask

  task automatic test_modes();
    logic [63:0] got;
    int c;
    loopback = 1'b0;
    for (int m = 1; m < 4; m++) begin
      ack_pulse();
      c = rxv_cnt[m];
      do_load(m, 32'h000000C3);
      ss_low(m);
      xfer_word(m, m / 2, m % 2, 8, 64'h3C, got);
      ss_high(m);
      n_tests++; if (got[7:0] !== 8'hC3) begin n_fail++;
        $display("FAIL mode%0d_miso got=%h exp=c3", m, got[7:0]); end
      n_tests++; if (rx_data8[m] !== 8'h3C) begin n_fail++;
        $display("FAIL mode%0d_rx got=%h exp=3c", m, rx_data8[m]); end
      n_tests++; if (rxv_cnt[m] - c !== 1) begin n_fail++;
        $display("FAIL mode%0d_valid_count got=%0d exp=1", m, rxv_cnt[m] - c); end
    end
  endtask

  task automatic test_abort();
    logic [63:0] got;
    int c, f;
    ack_pulse();
    c = rxv_cnt[0];
    f = fe_cnt[0];
    ss_low(0);
    xfer_word(0, 0, 0, 13, 64'h1ABC, got);
    ss_high(0);
    n_tests++; if (fe_cnt[0] - f !== 1) begin n_fail++;
      $display("FAIL abort_frame_error got=%0d exp=1", fe_cnt[0] - f); end
    n_tests++; if (rxv_cnt[0] - c !== 0) begin n_fail++;
      $display("FAIL abort_no_valid got=%0d exp=0", rxv_cnt[0] - c); end
    n_tests++; if (rx_data0 !== 32'h33333333) begin n_fail++;
      $display("FAIL abort_rx_held got=%h exp=33333333", rx_data0); end
    ss_low(0);
    xfer_word(0, 0, 0, 32, 64'h12345678, got);
    ss_high(0);
    n_tests++; if (rx_data0 !== 32'h12345678) begin n_fail++;
      $display("FAIL abort_next_rx got=%h exp=12345678", rx_data0); end
    n_tests++; if (got[31:0] !== 32'h0) begin n_fail++;
      $display("FAIL abort_next_miso got=%h exp=00000000", got[31:0]); end
    n_tests++; if (rxv_cnt[0] - c !== 1) begin n_fail++;
      $display("FAIL abort_next_valid got=%0d exp=1", rxv_cnt[0] - c); end
  endtask

  task automatic test_overrun();
    logic [63:0] got;
    int c;
    ack_pulse();
    n_tests++; if (rx_overrun_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL ovr_start got=%b exp=0", rx_overrun_a[0]); end
    c = rxv_cnt[0];
    ss_low(0);
    do_load(0, 32'h600DF00D);
    n_tests++; if (tx_ready_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL ovr_tx_ready_full got=%b exp=0", tx_ready_a[0]); end
    do_load(0, 32'h0BAD0BAD);
    xfer_word(0, 0, 0, 32, 64'hCAFEF00D, got);
    n_tests++; if (got[31:0] !== 32'h0) begin n_fail++;
      $display("FAIL ovr_miso1 got=%h exp=00000000", got[31:0]); end
    n_tests++; if (rx_overrun_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL ovr_after_first got=%b exp=0", rx_overrun_a[0]); end
    n_tests++; if (tx_ready_a[0] !== 1'b1) begin n_fail++;
      $display("FAIL ovr_tx_ready_drained got=%b exp=1", tx_ready_a[0]); end
    xfer_word(0, 0, 0, 32, 64'h0BADBEEF, got);
    n_tests++; if (got[31:0] !== 32'h600DF00D) begin n_fail++;
      $display("FAIL ovr_miso2 got=%h exp=600df00d", got[31:0]); end
    n_tests++; if (rx_overrun_a[0] !== 1'b1) begin n_fail++;
      $display("FAIL ovr_set got=%b exp=1", rx_overrun_a[0]); end
    n_tests++; if (rx_data0 !== 32'h0BADBEEF) begin n_fail++;
      $display("FAIL ovr_rx_overwritten got=%h exp=0badbeef", rx_data0); end
    ss_high(0);
    @(posedge clock);
    #50 rx_ack = 1'b1;
    @(posedge clock);
    #50;
    n_tests++; if (rx_overrun_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL ovr_cleared got=%b exp=0", rx_overrun_a[0]); end
    rx_ack = 1'b0;
    n_tests++; if (rxv_cnt[0] - c !== 2) begin n_fail++;
      $display("FAIL ovr_valid_count got=%0d exp=2", rxv_cnt[0] - c); end
  endtask

  task automatic test_mid_reset();
    logic [63:0] got;
    int c;
    ack_pulse();
    ss_low(0);
    xfer_word(0, 0, 0, 10, 64'h3A5, got);
    reset_n = 1'b0;
    #100;
    n_tests++; if (miso_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL mrst_miso got=%b exp=0", miso_a[0]); end
    n_tests++; if (miso_oe_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL mrst_miso_oe got=%b exp=0", miso_oe_a[0]); end
    n_tests++; if (tx_ready_a[0] !== 1'b1) begin n_fail++;
      $display("FAIL mrst_tx_ready got=%b exp=1", tx_ready_a[0]); end
    n_tests++; if (rx_data0 !== 32'h0) begin n_fail++;
      $display("FAIL mrst_rx_data got=%h exp=00000000", rx_data0); end
    n_tests++; if (rx_valid_a[0] !== 1'b0 || frame_error_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL mrst_pulses got=%b%b exp=00", rx_valid_a[0], frame_error_a[0]); end
    n_tests++; if (rx_overrun_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL mrst_overrun got=%b exp=0", rx_overrun_a[0]); end
    #400 reset_n = 1'b1;
    c = rxv_cnt[0];
    xfer_word(0, 0, 0, 22, 64'h155555, got);
    n_tests++; if (miso_oe_a[0] !== 1'b0) begin n_fail++;
      $display("FAIL mrst_ignored_oe got=%b exp=0", miso_oe_a[0]); end
    ss_high(0);
    n_tests++; if (rxv_cnt[0] - c !== 0) begin n_fail++;
      $display("FAIL mrst_ignored_valid got=%0d exp=0", rxv_cnt[0] - c); end
    ss_low(0);
    xfer_word(0, 0, 0, 32, 64'hDEADBEEF, got);
    ss_high(0);
    n_tests++; if (rx_data0 !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL mrst_clean_rx got=%h exp=deadbeef", rx_data0); end
    n_tests++; if (got[31:0] !== 32'h0) begin n_fail++;
      $display("FAIL mrst_clean_miso got=%h exp=00000000", got[31:0]); end
    n_tests++; if (rxv_cnt[0] - c !== 1) begin n_fail++;
      $display("FAIL mrst_clean_valid got=%0d exp=1", rxv_cnt[0] - c); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      sclk_a[k]    = (k >= 2);
      ss_a[k]      = 1'b1;
      tx_load_a[k] = 1'b0;
    end
    mosi     = 1'b0;
    loopback = 1'b0;
    rx_ack   = 1'b0;
    tx_data0 = '0;
    tx_data8 = '0;
    test_reset();
    test_loopback();
    test_burst();
    test_modes();
    test_abort();
    test_overrun();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
